dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of requester ports.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports p0_req / p1_req  input  1 each  access request, held high until the matching gnt.
REQ-005 SHALL have ports p0_we / p1_we  input  1 each  1 = write, 0 = read.
REQ-006 SHALL have ports p0_addr / p1_addr  input  ADDR_W each  byte address; bits [1:0] ignored.
REQ-007 SHALL have ports p0_be / p1_be  input  4 each  write byte enables, already lane-shifted.
REQ-008 SHALL have ports p0_wdata / p1_wdata  input  32 each  write data, already lane-shifted.
REQ-009 SHALL have ports p0_gnt / p1_gnt  output  1 each  one-cycle pulse: request accepted and issued.
REQ-010 SHALL have ports p0_rvalid / p1_rvalid  output  1 each  one-cycle pulse: rdata valid for that port.
REQ-011 SHALL have port rdata  output  32  read data, meaningful only while an rvalid is high.
REQ-012 SHALL have ports mem_en, mem_we  output  1 each  memory cycle enable and write strobe.
REQ-013 SHALL have ports mem_addr (ADDR_W-2), mem_be (4), mem_wdata (32)  output  memory word address, byte enables, write data.
REQ-014 SHALL have port mem_rdata  input  32  synchronous-read memory data, valid the cycle after mem_en with mem_we=0.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-016 IDLE: if any req is high, SHALL select a winner, register its we/addr[ADDR_W-1:2]/be/wdata, and go to ISSUE; otherwise stay in IDLE.
REQ-017 ISSUE: SHALL drive mem_en=1, mem_we=registered we, mem_addr/mem_be/mem_wdata from the registered values, and pulse the winner's gnt; next state is RESP for a read, IDLE for a write.
REQ-018 RESP: SHALL pulse the winner's rvalid with rdata=mem_rdata (combinational pass-through), then go to IDLE.
REQ-019 Latency from req sampled in IDLE: gnt at +1 cycle, rvalid at +2 cycles; read occupancy 3 cycles, write occupancy 2 cycles.
REQ-020 Outside ISSUE, mem_en, mem_we and mem_be SHALL be 0; gnt/rvalid SHALL never be high for both ports at once.
REQ-021 Requests arriving or changing during ISSUE/RESP SHALL be ignored until the next IDLE; the loser of a tie SHALL keep req high and is served on a later IDLE.
REQ-022 A write with be=4'b0000 SHALL still run a full cycle (mem_en=1, mem_we=1, mem_be=0) and pulse gnt.
REQ-023 A requester dropping req before its gnt SHALL NOT cancel an already-selected transaction.

Reset
REQ-024 While rst is high at a clock edge: state SHALL become IDLE; all outputs and registered request fields SHALL be 0; the round-robin pointer SHALL be set so port 0 wins the next tie.
REQ-025 Reset during ISSUE or RESP SHALL abort the transaction; no gnt or rvalid SHALL follow for it.

Configuration
REQ-026 Macro DMEM_ARB_RR_EN defined: ties SHALL be resolved round-robin; the port not granted most recently wins; the pointer updates on each gnt.
REQ-027 Macro DMEM_ARB_RR_EN undefined: port 0 SHALL always win ties (fixed priority); the pointer logic SHALL be absent.

Verification
REQ-028 p0 read addr=0x10 alone, mem_rdata=0xDEADBEEF in RESP -> mem_addr=0x4, p0_gnt at T+1, p0_rvalid with rdata=0xDEADBEEF at T+2.
REQ-029 p1 write addr=0x23, be=4'b1000, wdata=0xAB000000 -> ISSUE with mem_we=1, mem_addr=0x8, mem_be=4'b1000; back in IDLE at T+2; no rvalid.
REQ-030 p0 and p1 reads held continuously with RR enabled -> grants alternate p0,p1,p0,p1 every 3 cycles; with RR disabled -> p0 every grant.
REQ-031 rst asserted in the RESP cycle of a p0 read -> no p0_rvalid, all outputs 0 next cycle, FSM in IDLE.
REQ-032 Write with be=0 from p0 while p1 requests -> p0 cycle with mem_be=0 and p0_gnt, then p1 served on the following IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous data memory.
// Ties go to port 0 by default; define DMEM_ARB_RR_EN for round-robin tie-breaking.
module dmem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [3:0]        p0_be,
    input  logic [31:0]       p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [3:0]        p1_be,
    input  logic [31:0]       p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // state | meaning
    // IDLE  | waiting for a request; selects and captures the winner
    // ISSUE | memory cycle driven, winner's gnt pulsed
    // RESP  | read data returned, winner's rvalid pulsed
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              sel;
    logic              issue, resp;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{p0_addr[1:0], p1_addr[1:0]};

`ifdef DMEM_ARB_RR_EN
    logic rr_q, rr_d;   // port that wins the next tie

    always_comb begin
        sel  = ~p0_req;
        if (p0_req && p1_req) begin
            sel = rr_q;
        end
        rr_d = rr_q;
        if (issue) begin
            rr_d = ~win_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign sel = ~p0_req;
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_d = ISSUE;
                    win_d   = sel;
                    if (sel) begin
                        we_d    = p1_we;
                        addr_d  = p1_addr[ADDR_W-1:2];
                        be_d    = p1_be;
                        wdata_d = p1_wdata;
                    end else begin
                        we_d    = p0_we;
                        addr_d  = p0_addr[ADDR_W-1:2];
                        be_d    = p0_be;
                        wdata_d = p0_wdata;
                    end
                end
            end
            ISSUE:   state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Pulses are masked while rst is high so an aborted transaction never shows a gnt/rvalid.
    assign issue     = (state_q == ISSUE) && !rst;
    assign resp      = (state_q == RESP) && !rst;
    assign p0_gnt    = issue && !win_q;
    assign p1_gnt    = issue && win_q;
    assign p0_rvalid = resp && !win_q;
    assign p1_rvalid = resp && win_q;
    assign rdata     = resp ? mem_rdata : 32'h0;
    assign mem_en    = issue;
    assign mem_we    = issue && we_q;
    assign mem_be    = issue ? be_q : 4'h0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner sequences, random vs. reference model.
// Behaves as a 16-word synchronous memory behind the arbiter.
module tb_dmem_arbiter;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [3:0]    p0_be, p1_be;
    logic [31:0]   p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0]   rdata;
    logic          mem_en, mem_we;
    logic [AW-3:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_be(p0_be), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_be(p1_be), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic        load_mem;
    logic [31:0] bmem [16];

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 | 32'(i));
    endfunction

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) bmem[i] <= init_word(i);
            mem_rdata <= 32'h0;
        end else begin
            if (mem_en && mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) bmem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_en && !mem_we) mem_rdata <= bmem[mem_addr[3:0]];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input bit p, input bit req, input bit we, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] wd);
        if (p) begin
            p1_req = req; p1_we = we; p1_addr = a; p1_be = be; p1_wdata = wd;
        end else begin
            p0_req = req; p0_we = we; p0_addr = a; p0_be = be; p0_wdata = wd;
        end
    endtask

    task automatic clear_inputs();
        drive_port(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset(input bit reload);
        clear_inputs();
        rst = 1'b1;
        load_mem = reload;
        step();
        step();
        rst = 1'b0;
        load_mem = 1'b0;
    endtask

    function automatic logic [127:0] all_outs();
        return {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_en, mem_we, mem_be,
                mem_addr, mem_wdata, rdata};
    endfunction

    function automatic logic [9:0] ctl_outs();
        return {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_en, mem_we, mem_be};
    endfunction

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [29:0] exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic run_single(input vec_t v);
        drive_port(v.port, 1'b1, v.we, v.addr, v.be, v.wdata);
        step();
        chk("tbl_gnt", {p0_gnt, p1_gnt}, v.port ? 2'b01 : 2'b10);
        chk("tbl_en_we", {mem_en, mem_we}, {1'b1, v.we});
        chk("tbl_addr", mem_addr, v.exp_maddr);
        chk("tbl_be_wdata", {mem_be, mem_wdata}, {v.be, v.wdata});
        drive_port(v.port, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        if (v.we) begin
            chk("tbl_wr_idle", ctl_outs(), 10'h0);
        end else begin
            chk("tbl_rvalid", {p0_rvalid, p1_rvalid, p0_gnt, p1_gnt, mem_en},
                {!v.port, v.port, 3'b000});
            chk("tbl_rdata", rdata, v.exp_rdata);
            step();
            chk("tbl_rd_idle", ctl_outs(), 10'h0);
        end
    endtask

    typedef struct {
        bit          gnt0, gnt1, rv0, rv1, en, we;
        logic [3:0]  be;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    vec_t tbl[7];
    exp_t ring[8];

    initial begin
        bit          pend[2];
        bit          rwe[2];
        logic [31:0] raddr[2];
        logic [3:0]  rbe[2];
        logic [31:0] rwd[2];
        logic [31:0] refmem[16];
        int          gport[4];
        int          gcyc[4];
        int          ng, both, idle_from, ptr, w, c, idx;
        exp_t        e;

        tbl[0] = '{port:1'b0, we:1'b0, addr:32'h10, be:4'hF, wdata:32'h0,        exp_maddr:30'h4, exp_rdata:32'hDEADBEEF};
        tbl[1] = '{port:1'b1, we:1'b1, addr:32'h23, be:4'h8, wdata:32'hAB000000, exp_maddr:30'h8, exp_rdata:32'h0};
        tbl[2] = '{port:1'b1, we:1'b0, addr:32'h20, be:4'hF, wdata:32'h0,        exp_maddr:30'h8, exp_rdata:32'hAB000008};
        tbl[3] = '{port:1'b0, we:1'b1, addr:32'h3C, be:4'h3, wdata:32'h00005A5A, exp_maddr:30'hF, exp_rdata:32'h0};
        tbl[4] = '{port:1'b0, we:1'b0, addr:32'h3E, be:4'hF, wdata:32'h0,        exp_maddr:30'hF, exp_rdata:32'h10005A5A};
        tbl[5] = '{port:1'b0, we:1'b1, addr:32'h10, be:4'h0, wdata:32'hFFFFFFFF, exp_maddr:30'h4, exp_rdata:32'h0};
        tbl[6] = '{port:1'b1, we:1'b0, addr:32'h12, be:4'hF, wdata:32'h0,        exp_maddr:30'h4, exp_rdata:32'hDEADBEEF};

        clear_inputs();
        rst = 1'b1;
        load_mem = 1'b1;
        step();
        chk("reset_outputs", all_outs(), 128'h0);
        step();
        rst = 1'b0;
        load_mem = 1'b0;

        for (int i = 0; i < 7; i++) run_single(tbl[i]);

        // Both ports hold read requests continuously.
        do_reset(1'b0);
        drive_port(1'b0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
        drive_port(1'b1, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
        ng = 0;
        both = 0;
        for (int k = 1; k <= 16 && ng < 4; k++) begin
            step();
            if ((p0_gnt && p1_gnt) || (p0_rvalid && p1_rvalid)) both++;
            if (p0_gnt || p1_gnt) begin
                gport[ng] = p1_gnt ? 1 : 0;
                gcyc[ng] = k;
                ng++;
            end
        end
        clear_inputs();
        chk("tie_grant_count", ng, 4);
        chk("tie_exclusive", both, 0);
        for (int k = 0; k < ng; k++) begin
`ifdef DMEM_ARB_RR_EN
            chk("tie_order", gport[k], k % 2);
`else
            chk("tie_order", gport[k], 0);
`endif
            if (k > 0) chk("tie_spacing", gcyc[k] - gcyc[k-1], 3);
        end
        step();
        step();

        // Reset in the RESP cycle of a p0 read.
        do_reset(1'b0);
        drive_port(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        chk("rstresp_gnt", p0_gnt, 1'b1);
        clear_inputs();
        step();
        rst = 1'b1;
        #1;
        chk("rstresp_no_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
        step();
        chk("rstresp_outputs", all_outs(), 128'h0);
        rst = 1'b0;
        drive_port(1'b1, 1'b1, 1'b1, 32'h30, 4'h1, 32'h11);
        step();
        chk("rstresp_idle_then_gnt", {p0_gnt, p1_gnt, p0_rvalid}, 3'b010);
        clear_inputs();
        step();

        // Reset in the ISSUE cycle.
        drive_port(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        clear_inputs();
        rst = 1'b1;
        #1;
        chk("rstissue_no_gnt", {p0_gnt, mem_en}, 2'b00);
        step();
        rst = 1'b0;
        step();
        chk("rstissue_no_rvalid", ctl_outs(), 10'h0);

        // Zero-byte-enable write from p0 while p1 waits.
        do_reset(1'b0);
        drive_port(1'b0, 1'b1, 1'b1, 32'h30, 4'h0, 32'h12345678);
        drive_port(1'b1, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
        step();
        chk("be0_p0_issue", {p0_gnt, p1_gnt, mem_en, mem_we, mem_be}, {4'b1011, 4'h0});
        drive_port(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("be0_idle", ctl_outs(), 10'h0);
        step();
        chk("be0_p1_gnt", {p0_gnt, p1_gnt, mem_addr}, {2'b01, 30'h5});
        drive_port(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("be0_p1_rdata", {p1_rvalid, rdata}, {1'b1, 32'h10000005});
        step();

        // Requester drops req right after selection.
        drive_port(1'b1, 1'b1, 1'b0, 32'h3C, 4'hF, 32'h0);
        step();
        clear_inputs();
        chk("drop_gnt", p1_gnt, 1'b1);
        step();
        chk("drop_rdata", {p1_rvalid, rdata}, {1'b1, 32'h10005A5A});
        step();

        // Random traffic against a transaction-level reference model.
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) refmem[i] = init_word(i);
        for (int i = 0; i < 8; i++) ring[i] = '{default: '0};
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        idle_from = 0;
        ptr = 0;
        c = 0;
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && n < 590 && $urandom_range(0, 2) != 0) begin
                    pend[p]  = 1'b1;
                    rwe[p]   = 1'($urandom_range(0, 1));
                    raddr[p] = $urandom;
                    rbe[p]   = 4'($urandom);
                    rwd[p]   = $urandom;
                end
                if (pend[p]) drive_port(p[0], 1'b1, rwe[p], raddr[p], rbe[p], rwd[p]);
                else drive_port(p[0], 1'b0, 1'($urandom), $urandom, 4'($urandom), $urandom);
            end
            if (c >= idle_from && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? ptr : (pend[1] ? 1 : 0);
                e = '{default: '0};
                e.gnt0 = (w == 0);
                e.gnt1 = (w == 1);
                e.en = 1'b1;
                e.we = rwe[w];
                e.be = rbe[w];
                e.addr = raddr[w][31:2];
                e.wdata = rwd[w];
                ring[(c + 1) % 8] = e;
                idx = int'(raddr[w][5:2]);
                if (rwe[w]) begin
                    for (int b = 0; b < 4; b++)
                        if (rbe[w][b]) refmem[idx][8*b +: 8] = rwd[w][8*b +: 8];
                    idle_from = c + 2;
                end else begin
                    e = '{default: '0};
                    e.rv0 = (w == 0);
                    e.rv1 = (w == 1);
                    e.rdata = refmem[idx];
                    ring[(c + 2) % 8] = e;
                    idle_from = c + 3;
                end
`ifdef DMEM_ARB_RR_EN
                ptr = 1 - w;
`endif
                pend[w] = 1'b0;
            end
            step();
            c++;
            e = ring[c % 8];
            ring[c % 8] = '{default: '0};
            chk("rand_ctl", ctl_outs(), {e.gnt0, e.gnt1, e.rv0, e.rv1, e.en, e.we, e.be});
            if (e.en) chk("rand_issue", {mem_addr, mem_wdata}, {e.addr, e.wdata});
            if (e.rv0 || e.rv1) chk("rand_rdata", rdata, e.rdata);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
